dsd_out_framer: RTL

//  Output stage downstream of the SDM modulator. Takes the 1-bit SDM symbol stream on dsd_clk and frames it into
//  8-bit DSD bytes. Drives a re-timed serial DSD bit plus a parallel byte/strobe for a DoP or I2S packer.

---
 rtl/dsd_out_framer.sv | 116 +++++++++++
 1 files changed

// File: rtl/dsd_out_framer.sv
// Frames the 1-bit SDM symbol stream into 8-bit DSD bytes. Mute and unmute take effect only on byte
// boundaries. A run-length detector flags modulator overload and can optionally force muting.
module dsd_out_framer #(
    parameter logic [7:0]  MUTE_PAT     = 8'h69,
    parameter int unsigned RUN_MAX      = 28,
    parameter int unsigned UNMUTE_BYTES = 2,
    parameter bit          AUTO_MUTE    = 1'b1
) (
    input  logic       dsd_clk,
    input  logic       reset_n,
    input  logic       sdm_bit,
    input  logic       sdm_valid,
    input  logic       mute_req,
    input  logic       ovf_clr,
    output logic       dsd_data,
    output logic [7:0] byte_out,
    output logic       byte_stb,
    output logic       muted,
    output logic       overflow
);

    typedef enum logic {ST_PLAY, ST_MUTED} state_t;

    localparam logic [7:0] RUN_MAX_B = 8'(RUN_MAX);
    localparam logic [7:0] UNMUTE_B  = 8'(UNMUTE_BYTES);

    state_t     state, state_next;
    logic [2:0] bit_cnt;
    logic [6:0] in_sr;
    logic [7:0] out_sr, out_sr_next;
    logic [7:0] run_len, run_len_next;
    logic [7:0] holdoff, holdoff_next;
    logic [7:0] candidate;
    logic       boundary, mute_cond, overflow_next;

    // in_sr[0] is the bit sampled on the previous edge; run_len > 0 guarantees it was valid.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        run_len_next = 8'd1;
        if (!sdm_valid)
            run_len_next = 8'd0;
        else if ((sdm_bit == in_sr[0]) && (run_len != 8'd0))
            run_len_next = (run_len == RUN_MAX_B) ? run_len : run_len + 8'd1;
    end

    // A run reaching RUN_MAX on the same edge as ovf_clr keeps the flag set.
    assign overflow_next = (overflow & ~ovf_clr) | (run_len_next == RUN_MAX_B);

    assign boundary  = (bit_cnt == 3'd7);
    assign candidate = {in_sr, sdm_bit};
    assign mute_cond = mute_req | ~sdm_valid | (AUTO_MUTE & overflow_next);

    always_comb begin
        state_next   = state;
        holdoff_next = holdoff;
        if (boundary) begin
            case (state)
                ST_PLAY: begin
                    if (mute_cond) begin
                        state_next   = ST_MUTED;
                        holdoff_next = 8'd0;
                    end
                end
                ST_MUTED: begin
                    if (mute_cond) begin
                        holdoff_next = 8'd0;
                    end else if (holdoff + 8'd1 == UNMUTE_B) begin
                        state_next   = ST_PLAY;
                        holdoff_next = 8'd0;
                    end else begin
                        holdoff_next = holdoff + 8'd1;
                    end
                end
                default: state_next = ST_MUTED;
            endcase
        end
    end

    // The freshly decided state selects the byte loaded on the same boundary edge.
    always_comb begin
        out_sr_next = {out_sr[6:0], 1'b0};
        if (boundary)
            out_sr_next = (state_next == ST_PLAY) ? candidate : MUTE_PAT;
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge dsd_clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt  <= 3'd0;
            in_sr    <= 7'd0;
            out_sr   <= MUTE_PAT;
            dsd_data <= 1'b0;
            byte_out <= MUTE_PAT;
            byte_stb <= 1'b0;
            state    <= ST_MUTED;
            muted    <= 1'b1;
            overflow <= 1'b0;
            run_len  <= 8'd0;
            holdoff  <= 8'd0;
        end else begin
            bit_cnt  <= bit_cnt + 3'd1;
            in_sr    <= {in_sr[5:0], sdm_bit};
            out_sr   <= out_sr_next;
            dsd_data <= out_sr_next[7];
            byte_stb <= boundary;
            if (boundary)
                byte_out <= out_sr_next;
            state    <= state_next;
            muted    <= (state_next == ST_MUTED);
            overflow <= overflow_next;
            run_len  <= run_len_next;
            holdoff  <= holdoff_next;
        end
    end

endmodule
